// File: rtl/debug_mem_pkg.sv
// Shared types and constants for the debug on-chip RAM arbiter.
//   ADDR_W / DATA_W / BE_W : default bus geometry (64K x 32, 4 byte lanes)
//   arb_state_t            : arbiter ownership state
//   sat_inc                : saturating 32-bit increment for the statistics counters
package debug_mem_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/debug_memory_arbiter_if.sv
// Avalon-MM master-side bus, one instance per master of the debug RAM arbiter.
//   address/byteenable/read/write/writedata/lock : master -> arbiter
//   waitrequest/readdata/readdatavalid           : arbiter -> master
// Modports: master (bus initiator), slave (arbiter side).
interface debug_memory_arbiter_if #(
    parameter int unsigned ADDR_W = debug_mem_pkg::ADDR_W,
    parameter int unsigned DATA_W = debug_mem_pkg::DATA_W
);

    logic [ADDR_W-1:0]   address;
    logic [DATA_W/8-1:0] byteenable;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic                lock;
    logic                waitrequest;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;

    modport master (
        output address, byteenable, read, write, writedata, lock,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, read, write, writedata, lock,
        output waitrequest, readdata, readdatavalid
    );

endinterface

// File: rtl/debug_mem_rr_pick.sv
// Two-way round-robin pick.
//   req0_i, req1_i : requests from master 0 and master 1
//   last_grant_i   : master granted most recently (1 = master 1)
//   grant_o        : one-hot grant, bit N = master N; zero when nobody requests
module debug_mem_rr_pick (
    input  logic       req0_i,
    input  logic       req1_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = {req1_i, req0_i};
        // On a tie, the master that did not win last time goes first.
        if (req0_i && req1_i) begin
            grant_o = last_grant_i ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/debug_memory_arbiter.sv
// Two-master Avalon-MM arbiter in front of the single-port debug on-chip RAM
// (registered inputs, unregistered q). One transfer per cycle; reads return one
// cycle after acceptance with a readdatavalid pulse to the owning master.
// Ports:
//   clk, reset_n       : clock, asynchronous active-low reset
//   m0, m1             : master buses (slave modport)
//   mem_*              : RAM side; mem_clken is tied high
// Optional feature (macro DEBUG_MEM_ARB_STATS_EN):
//   stat_clear in, stat_grant0/stat_grant1/stat_conflict out -- saturating counters
//   of accepted transfers per master and of cycles with both masters requesting.
module debug_memory_arbiter #(
    parameter int unsigned ADDR_W   = debug_mem_pkg::ADDR_W,
    parameter int unsigned DATA_W   = debug_mem_pkg::DATA_W,
    parameter int unsigned MAX_LOCK = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    debug_memory_arbiter_if.slave m0,
    debug_memory_arbiter_if.slave m1,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic                  mem_clken,
    input  logic [DATA_W-1:0]     mem_readdata
`ifdef DEBUG_MEM_ARB_STATS_EN
    ,
    input  logic                  stat_clear,
    output logic [31:0]           stat_grant0,
    output logic [31:0]           stat_grant1,
    output logic [31:0]           stat_conflict
`endif
);

    import debug_mem_pkg::*;

    localparam int unsigned     CntW    = $clog2(MAX_LOCK) + 1;
    localparam logic [CntW-1:0] LockMax = CntW'(MAX_LOCK - 1);

    arb_state_t      state_q, state_d;
    logic            last_grant_q, last_grant_d;
    logic [CntW-1:0] lock_cnt_q, lock_cnt_d;
    logic            rd_pend_q, rd_pend_d;
    logic            rd_owner_q, rd_owner_d;

    logic       req0, req1;
    logic [1:0] rr_grant;
    logic [1:0] grant;

    assign req0 = m0.read | m0.write;
    assign req1 = m1.read | m1.write;

    debug_mem_rr_pick u_rr_pick (
        .req0_i       (req0),
        .req1_i       (req1),
        .last_grant_i (last_grant_q),
        .grant_o      (rr_grant)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            lock_cnt_q   <= '0;
            rd_pend_q    <= 1'b0;
            rd_owner_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            lock_cnt_q   <= lock_cnt_d;
            rd_pend_q    <= rd_pend_d;
            rd_owner_q   <= rd_owner_d;
        end
    end

    // Next-state logic: ownership, lock timeout and the read-return pipe.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        lock_cnt_d   = lock_cnt_q;

        if (grant[0]) last_grant_d = 1'b0;
        if (grant[1]) last_grant_d = 1'b1;

        unique case (state_q)
            IDLE: begin
                // The grant cycle itself already makes the other master wait,
                // so it counts towards the lock budget.
                if (grant[0] && m0.lock) begin
                    state_d    = OWN0;
                    lock_cnt_d = CntW'(req1);
                end else if (grant[1] && m1.lock) begin
                    state_d    = OWN1;
                    lock_cnt_d = CntW'(req0);
                end
            end
            OWN0: begin
                // Leaving with last_grant=0 hands the next tie to m1.
                if (!req0 || !m0.lock || lock_cnt_q == LockMax) begin
                    state_d    = IDLE;
                    lock_cnt_d = '0;
                end else if (req1) begin
                    lock_cnt_d = lock_cnt_q + CntW'(1);
                end
            end
            OWN1: begin
                if (!req1 || !m1.lock || lock_cnt_q == LockMax) begin
                    state_d    = IDLE;
                    lock_cnt_d = '0;
                end else if (req0) begin
                    lock_cnt_d = lock_cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d    = IDLE;
                lock_cnt_d = '0;
            end
        endcase

        // read+write together is a write, so it never produces a read return.
        rd_pend_d  = (grant[0] & m0.read & ~m0.write) | (grant[1] & m1.read & ~m1.write);
        rd_owner_d = grant[1] & m1.read & ~m1.write;
    end

    // Output logic: grant decode and RAM-side mux.
    always_comb begin
        grant = 2'b00;
        if (reset_n) begin
            unique case (state_q)
                IDLE:    grant = rr_grant;
                OWN0:    grant = {1'b0, req0};
                OWN1:    grant = {req1, 1'b0};
                default: grant = 2'b00;
            endcase
        end

        mem_address    = m0.address;
        mem_writedata  = m0.writedata;
        mem_byteenable = '1;
        mem_write      = 1'b0;
        if (grant[1]) begin
            mem_address   = m1.address;
            mem_writedata = m1.writedata;
            if (m1.write) begin
                mem_write      = 1'b1;
                mem_byteenable = m1.byteenable;
            end
        end else if (grant[0]) begin
            if (m0.write) begin
                mem_write      = 1'b1;
                mem_byteenable = m0.byteenable;
            end
        end
        mem_chipselect = |grant;
        mem_clken      = 1'b1;
    end

    assign m0.waitrequest   = ~grant[0];
    assign m1.waitrequest   = ~grant[1];
    assign m0.readdata      = mem_readdata;
    assign m1.readdata      = mem_readdata;
    assign m0.readdatavalid = rd_pend_q & ~rd_owner_q;
    assign m1.readdatavalid = rd_pend_q & rd_owner_q;

`ifdef DEBUG_MEM_ARB_STATS_EN
    logic [31:0] stat_grant0_q, stat_grant0_d;
    logic [31:0] stat_grant1_q, stat_grant1_d;
    logic [31:0] stat_conflict_q, stat_conflict_d;

    always_comb begin
        stat_grant0_d   = stat_grant0_q;
        stat_grant1_d   = stat_grant1_q;
        stat_conflict_d = stat_conflict_q;
        if (stat_clear) begin
            stat_grant0_d   = '0;
            stat_grant1_d   = '0;
            stat_conflict_d = '0;
        end else begin
            if (grant[0])      stat_grant0_d   = sat_inc(stat_grant0_q);
            if (grant[1])      stat_grant1_d   = sat_inc(stat_grant1_q);
            if (req0 && req1)  stat_conflict_d = sat_inc(stat_conflict_q);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_grant0_q   <= '0;
            stat_grant1_q   <= '0;
            stat_conflict_q <= '0;
        end else begin
            stat_grant0_q   <= stat_grant0_d;
            stat_grant1_q   <= stat_grant1_d;
            stat_conflict_q <= stat_conflict_d;
        end
    end

    assign stat_grant0   = stat_grant0_q;
    assign stat_grant1   = stat_grant1_q;
    assign stat_conflict = stat_conflict_q;
`endif

endmodule

// File: tb/tb_debug_memory_arbiter.sv
// Scoreboard bench for debug_memory_arbiter: the driver pushes expected grants,
// read returns and counter values; a negedge monitor pops and compares them.
module tb_debug_memory_arbiter;

    logic        clk;
    logic        reset_n;
    logic [15:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic        mem_clken;
    logic [31:0] mem_readdata;
`ifdef DEBUG_MEM_ARB_STATS_EN
    logic        stat_clear;
    logic [31:0] stat_grant0, stat_grant1, stat_conflict;
`endif

    debug_memory_arbiter_if m0_bus ();
    debug_memory_arbiter_if m1_bus ();

    debug_memory_arbiter #(
        .MAX_LOCK (4)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .m0             (m0_bus),
        .m1             (m1_bus),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata)
`ifdef DEBUG_MEM_ARB_STATS_EN
        ,
        .stat_clear     (stat_clear),
        .stat_grant0    (stat_grant0),
        .stat_grant1    (stat_grant1),
        .stat_conflict  (stat_conflict)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: registered address/data inputs, unregistered q.
    logic [31:0] ram [0:65535];
    logic [15:0] ram_addr_q;
    always @(posedge clk) begin
        if (mem_chipselect === 1'b1) begin
            ram_addr_q <= mem_address;
            if (mem_write === 1'b1) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
                end
            end
        end
    end
    assign mem_readdata = ram[ram_addr_q];

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] cyc;
    } rd_exp_t;

    rd_exp_t     exp0_q[$];
    rd_exp_t     exp1_q[$];
    logic [1:0]  wait_q[$];
`ifdef DEBUG_MEM_ARB_STATS_EN
    typedef struct packed {
        logic [31:0] g0;
        logic [31:0] g1;
        logic [31:0] cf;
    } stat_exp_t;
    stat_exp_t   stat_q[$];
`endif

    logic [31:0] cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_cmp = 0;
    int   n_err = 0;
    logic done  = 1'b0;

    task automatic check_rd(input int m, input logic [31:0] got);
        rd_exp_t e;
        logic    have;
        have = (m == 0) ? (exp0_q.size() > 0) : (exp1_q.size() > 0);
        n_cmp++;
        if (!have) begin
            n_err++;
            $display("FAIL rdvalid_m%0d: pulse at cyc %0d data %h, required no pulse", m, cyc, got);
        end else begin
            if (m == 0) e = exp0_q.pop_front();
            else        e = exp1_q.pop_front();
            if (e.cyc != cyc || got !== e.data) begin
                n_err++;
                $display("FAIL rddata_m%0d: got cyc %0d data %h, required cyc %0d data %h",
                         m, cyc, got, e.cyc, e.data);
            end
        end
    endtask

    // Monitor: sample mid-cycle, away from the active edge.
    always @(negedge clk) begin
        logic [1:0] ew;
`ifdef DEBUG_MEM_ARB_STATS_EN
        stat_exp_t  se;
`endif
        if (wait_q.size() > 0) begin
            ew = wait_q.pop_front();
            n_cmp++;
            if ({m0_bus.waitrequest, m1_bus.waitrequest} !== ew) begin
                n_err++;
                $display("FAIL waitrequest cyc %0d: got {m0,m1}=%b, required %b", cyc,
                         {m0_bus.waitrequest, m1_bus.waitrequest}, ew);
            end
            n_cmp++;
            if (mem_chipselect !== ~(ew[1] & ew[0])) begin
                n_err++;
                $display("FAIL chipselect cyc %0d: got %b, required %b", cyc, mem_chipselect,
                         ~(ew[1] & ew[0]));
            end
        end
        if (m0_bus.readdatavalid !== 1'b0) check_rd(0, m0_bus.readdata);
        if (m1_bus.readdatavalid !== 1'b0) check_rd(1, m1_bus.readdata);
`ifdef DEBUG_MEM_ARB_STATS_EN
        if (stat_q.size() > 0) begin
            se = stat_q.pop_front();
            n_cmp++;
            if ({stat_grant0, stat_grant1, stat_conflict} !== {se.g0, se.g1, se.cf}) begin
                n_err++;
                $display("FAIL stats: got g0=%0d g1=%0d cf=%0d, required g0=%0d g1=%0d cf=%0d",
                         stat_grant0, stat_grant1, stat_conflict, se.g0, se.g1, se.cf);
            end
        end
`endif
        if (done) begin
            n_cmp++;
            if (exp0_q.size() != 0 || exp1_q.size() != 0) begin
                n_err++;
                $display("FAIL missing_rdvalid: got %0d/%0d unreturned reads, required 0/0",
                         exp0_q.size(), exp1_q.size());
            end
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
            $finish;
        end
    end

    task automatic set_m(input int m, input logic rd, input logic wr, input logic lk,
                         input logic [15:0] a, input logic [3:0] be, input logic [31:0] wd);
        if (m == 0) begin
            m0_bus.read = rd; m0_bus.write = wr; m0_bus.lock = lk;
            m0_bus.address = a; m0_bus.byteenable = be; m0_bus.writedata = wd;
        end else begin
            m1_bus.read = rd; m1_bus.write = wr; m1_bus.lock = lk;
            m1_bus.address = a; m1_bus.byteenable = be; m1_bus.writedata = wd;
        end
    endtask

    task automatic idle_all();
        set_m(0, 1'b0, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
        set_m(1, 1'b0, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    endtask

    task automatic expect_rd(input int m, input logic [31:0] d);
        rd_exp_t e;
        e.data = d;
        e.cyc  = cyc + 1;
        if (m == 0) exp0_q.push_back(e);
        else        exp1_q.push_back(e);
    endtask

    // One bus cycle with the expected {m0,m1} waitrequest pattern.
    task automatic step(input logic w0, input logic w1);
        wait_q.push_back({w0, w1});
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
`ifdef DEBUG_MEM_ARB_STATS_EN
        stat_clear = 1'b0;
`endif
        idle_all();
        @(posedge clk);
        #1;

        // Reset: requests present but nothing granted.
        set_m(0, 1'b1, 1'b0, 1'b0, 16'h0010, 4'hF, 32'h0);
        set_m(1, 1'b1, 1'b0, 1'b0, 16'h0020, 4'hF, 32'h0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        reset_n = 1'b1;

        // First tie after reset goes to m0, then m1.
        set_m(0, 1'b0, 1'b1, 1'b0, 16'h0010, 4'hF, 32'hDEADBEEF);
        set_m(1, 1'b0, 1'b1, 1'b0, 16'h0020, 4'hF, 32'h11223344);
        step(1'b0, 1'b1);
        set_m(0, 1'b0, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
        step(1'b1, 1'b0);
        idle_all();

        // m0 read, latency 1.
        set_m(0, 1'b1, 1'b0, 1'b0, 16'h0010, 4'hF, 32'h0);
        expect_rd(0, 32'hDEADBEEF);
        step(1'b0, 1'b1);
        idle_all();
        step(1'b1, 1'b1);

        // Byte-lane write then immediate read of the same word.
        set_m(1, 1'b0, 1'b1, 1'b0, 16'h0020, 4'h2, 32'h0000AA00);
        step(1'b1, 1'b0);
        set_m(1, 1'b1, 1'b0, 1'b0, 16'h0020, 4'hF, 32'h0);
        expect_rd(1, 32'h1122AA44);
        step(1'b1, 1'b0);
        idle_all();
`ifdef DEBUG_MEM_ARB_STATS_EN
        stat_clear = 1'b1;
`endif
        step(1'b1, 1'b1);
`ifdef DEBUG_MEM_ARB_STATS_EN
        stat_clear = 1'b0;
`endif

        // Both reading every cycle: strict alternation starting with m0.
        set_m(0, 1'b1, 1'b0, 1'b0, 16'h0010, 4'hF, 32'h0);
        set_m(1, 1'b1, 1'b0, 1'b0, 16'h0020, 4'hF, 32'h0);
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) begin
                expect_rd(0, 32'hDEADBEEF);
                step(1'b0, 1'b1);
            end else begin
                expect_rd(1, 32'h1122AA44);
                step(1'b1, 1'b0);
            end
        end
        idle_all();
`ifdef DEBUG_MEM_ARB_STATS_EN
        stat_q.push_back('{g0: 32'd4, g1: 32'd4, cf: 32'd8});
`endif
        step(1'b1, 1'b1);
`ifdef DEBUG_MEM_ARB_STATS_EN
        stat_clear = 1'b1;
        step(1'b1, 1'b1);
        stat_clear = 1'b0;
        stat_q.push_back('{g0: 32'd0, g1: 32'd0, cf: 32'd0});
`endif

        // m0 locked: holds 4 cycles, m1 gets the 5th, m0 re-locks, then releases.
        set_m(0, 1'b1, 1'b0, 1'b1, 16'h0010, 4'hF, 32'h0);
        set_m(1, 1'b1, 1'b0, 1'b0, 16'h0020, 4'hF, 32'h0);
        for (int k = 0; k < 4; k++) begin
            expect_rd(0, 32'hDEADBEEF);
            step(1'b0, 1'b1);
        end
        expect_rd(1, 32'h1122AA44);
        step(1'b1, 1'b0);
        expect_rd(0, 32'hDEADBEEF);
        step(1'b0, 1'b1);
        set_m(0, 1'b1, 1'b0, 1'b0, 16'h0010, 4'hF, 32'h0);
        expect_rd(0, 32'hDEADBEEF);
        step(1'b0, 1'b1);
        expect_rd(1, 32'h1122AA44);
        step(1'b1, 1'b0);
        idle_all();
        step(1'b1, 1'b1);

        // read+write together is a write with no read return.
        set_m(0, 1'b1, 1'b1, 1'b0, 16'h0030, 4'hF, 32'h12345678);
        step(1'b0, 1'b1);
        set_m(0, 1'b1, 1'b0, 1'b0, 16'h0030, 4'hF, 32'h0);
        expect_rd(0, 32'h12345678);
        step(1'b0, 1'b1);
        idle_all();
        step(1'b1, 1'b1);

        // Reset right after an m1 read accept drops its return.
        set_m(1, 1'b1, 1'b0, 1'b0, 16'h0020, 4'hF, 32'h0);
        step(1'b1, 1'b0);
        reset_n = 1'b0;
        set_m(0, 1'b1, 1'b0, 1'b0, 16'h0010, 4'hF, 32'h0);
        step(1'b1, 1'b1);
        reset_n = 1'b1;
        set_m(0, 1'b0, 1'b1, 1'b0, 16'h0040, 4'hF, 32'hCAFEF00D);
        set_m(1, 1'b0, 1'b1, 1'b0, 16'h0044, 4'hF, 32'h0BADC0DE);
        step(1'b0, 1'b1);
        set_m(0, 1'b0, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
        step(1'b1, 1'b0);
        set_m(0, 1'b1, 1'b0, 1'b0, 16'h0040, 4'hF, 32'h0);
        set_m(1, 1'b1, 1'b0, 1'b0, 16'h0044, 4'hF, 32'h0);
        expect_rd(0, 32'hCAFEF00D);
        step(1'b0, 1'b1);
        expect_rd(1, 32'h0BADC0DE);
        step(1'b1, 1'b0);
        idle_all();
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);

        done = 1'b1;
        #100;
        $display("FAIL monitor_end: summary not reached");
        $fatal(1);
    end

endmodule
